// File: rtl/ipc_mailbox_fifo.sv
// Two-port inter-hart mailbox: A->B and B->A message FIFOs, each side on its own APB slave.
// Optional doorbell registers at 0x18/0x1C are built when IPC_MBOX_DOORBELL_EN is defined.
module ipc_mailbox_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int A_HART_ID  = 0,
  parameter int B_HART_ID  = 1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        a_psel,
  input  logic        a_penable,
  input  logic        a_pwrite,
  input  logic [31:0] a_paddr,
  input  logic [31:0] a_pwdata,
  output logic [31:0] a_prdata,
  output logic        a_pready,
  output logic        a_pslverr,
  input  logic        b_psel,
  input  logic        b_penable,
  input  logic        b_pwrite,
  input  logic [31:0] b_paddr,
  input  logic [31:0] b_pwdata,
  output logic [31:0] b_prdata,
  output logic        b_pready,
  output logic        b_pslverr,
  output logic        a_msg_irq,
  output logic        b_msg_irq
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  // APB handshake: a transfer completes in the single cycle where psel && penable is high;
  // pready is always 1, and prdata/pslverr are combinational in that cycle and 0 otherwise.
  // Index 0 is side A, 1 is side B; FIFO f carries words sent by side f to the other side.
  logic [1:0]        acc, wr;
  logic [1:0][3:0]   off;
  logic [1:0][31:0]  wdata, rdata, hart_id;
  logic [1:0]        slverr;

  assign acc     = {b_psel & b_penable, a_psel & a_penable};
  assign wr      = {b_pwrite, a_pwrite};
  assign off     = {b_paddr[5:2], a_paddr[5:2]};
  assign wdata   = {b_pwdata, a_pwdata};
  assign hart_id = {32'(B_HART_ID), 32'(A_HART_ID)};

  logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [1:0][PW-1:0]    wptr, rptr;
  logic [1:0][CNTW-1:0]  count, count_next;
  logic [1:0]            ovf, udf, irq_en, irq, irq_next;
  logic [1:0][7:0]       thr;
  logic [1:0]            push_req, pop_req, push_ok, pop_ok, flush, full, empty;
  logic [1:0]            ctrl_wr, clr_wr;
`ifdef IPC_MBOX_DOORBELL_EN
  logic [1:0][7:0]       db, db_next;
`endif

  logic unused_bits;
  assign unused_bits = ^{a_paddr[31:6], a_paddr[1:0], b_paddr[31:6], b_paddr[1:0], wdata};

  always_comb begin
    logic [31:0] head;
    logic [31:0] status;
    for (int s = 0; s < 2; s++) begin
      full[s]     = (count[s] == FULL_CNT);
      empty[s]    = (count[s] == '0);
      push_req[s] = acc[s] & wr[s] & (off[s] == 4'h0);
      pop_req[s]  = acc[s] & ~wr[s] & (off[s] == 4'h1);
      ctrl_wr[s]  = acc[s] & wr[s] & (off[s] == 4'h3);
      clr_wr[s]   = acc[s] & wr[s] & (off[s] == 4'h4);
    end
    // Full/empty are pre-cycle, so a same-cycle peer pop/push never rescues the access.
    for (int f = 0; f < 2; f++) begin
      push_ok[f]    = push_req[f] & ~full[f];
      pop_ok[f]     = pop_req[1-f] & ~empty[f];
      flush[f]      = (clr_wr[f] & wdata[f][8]) | (clr_wr[1-f] & wdata[1-f][9]);
      count_next[f] = flush[f] ? '0 : count[f] + CNTW'(push_ok[f]) - CNTW'(pop_ok[f]);
    end
`ifdef IPC_MBOX_DOORBELL_EN
    for (int s = 0; s < 2; s++) begin
      db_next[s] = db[s];
      if (acc[s] & wr[s] & (off[s] == 4'h7)) db_next[s] = db_next[s] & ~wdata[s][7:0];
      if (acc[1-s] & wr[1-s] & (off[1-s] == 4'h6)) db_next[s] = db_next[s] | wdata[1-s][7:0];
    end
`endif
    for (int s = 0; s < 2; s++) begin
      irq_next[s] = irq_en[s] & (thr[s] != 8'd0) & (9'(count_next[1-s]) >= 9'(thr[s]));
`ifdef IPC_MBOX_DOORBELL_EN
      irq_next[s] = irq_next[s] | (irq_en[s] & (|db_next[s]));
`endif
    end
    for (int s = 0; s < 2; s++) begin
      head                   = '0;
      head[DATA_WIDTH-1:0]   = mem[1-s][rptr[1-s]];
      status                 = '0;
      status[0]              = ~empty[1-s];
      status[1]              = full[s];
      status[2]              = ovf[s];
      status[3]              = udf[s];
      status[15:8]           = 8'(count[1-s]);
      status[23:16]          = 8'(count[s]);
      rdata[s]  = '0;
      slverr[s] = 1'b0;
      if (acc[s]) begin
        case (off[s])
          4'h0: slverr[s] = wr[s] & full[s];
          4'h1: begin
            if (wr[s] || empty[1-s]) slverr[s] = 1'b1;
            else rdata[s] = head;
          end
          4'h2: if (!wr[s]) rdata[s] = status;
          4'h3: if (!wr[s]) rdata[s] = {16'd0, thr[s], 7'd0, irq_en[s]};
          4'h4: ;
          4'h5: if (!wr[s]) rdata[s] = hart_id[s];
`ifdef IPC_MBOX_DOORBELL_EN
          4'h6: if (!wr[s]) rdata[s] = {24'd0, db[s]};
          4'h7: ;
`endif
          default: slverr[s] = 1'b1;
        endcase
      end
    end
  end

  // Storage has no reset; only accepted pushes write it.
  always_ff @(posedge pclk) begin
    for (int f = 0; f < 2; f++) begin
      if (push_ok[f]) mem[f][wptr[f]] <= wdata[f][DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= '0;
      udf    <= '0;
      irq_en <= 2'b11;
      thr    <= {8'd1, 8'd1};
      irq    <= '0;
`ifdef IPC_MBOX_DOORBELL_EN
      db     <= '0;
`endif
    end else begin
      count <= count_next;
      irq   <= irq_next;
`ifdef IPC_MBOX_DOORBELL_EN
      db    <= db_next;
`endif
      for (int f = 0; f < 2; f++) begin
        if (flush[f]) begin
          wptr[f] <= '0;
          rptr[f] <= '0;
        end else begin
          if (push_ok[f]) wptr[f] <= wptr[f] + PW'(1);
          if (pop_ok[f])  rptr[f] <= rptr[f] + PW'(1);
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (ctrl_wr[s]) begin
          irq_en[s] <= wdata[s][0];
          thr[s]    <= wdata[s][15:8];
        end
        if (push_req[s] && full[s]) ovf[s] <= 1'b1;
        else if (clr_wr[s] && wdata[s][2]) ovf[s] <= 1'b0;
        if (pop_req[s] && empty[1-s]) udf[s] <= 1'b1;
        else if (clr_wr[s] && wdata[s][3]) udf[s] <= 1'b0;
      end
    end
  end

  assign a_prdata  = rdata[0];
  assign a_pslverr = slverr[0];
  assign a_pready  = 1'b1;
  assign b_prdata  = rdata[1];
  assign b_pslverr = slverr[1];
  assign b_pready  = 1'b1;
  assign a_msg_irq = irq[0];
  assign b_msg_irq = irq[1];

endmodule

// File: tb/tb_ipc_mailbox_fifo.sv
// Directed bench for ipc_mailbox_fifo: APB driver tasks, per-port expected queues and a monitor.
module tb_ipc_mailbox_fifo;

  localparam logic [5:0] TXD = 6'h00, RXD = 6'h04, STA = 6'h08, CTL = 6'h0C;
  localparam logic [5:0] CLR = 6'h10, HID = 6'h14, DBL = 6'h18, DBC = 6'h1C;

  logic        pclk = 1'b0;
  logic        preset;
  logic        a_psel, a_penable, a_pwrite, a_pready, a_pslverr;
  logic [31:0] a_paddr, a_pwdata, a_prdata;
  logic        b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
  logic [31:0] b_paddr, b_pwdata, b_prdata;
  logic        a_msg_irq, b_msg_irq;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];
  logic [32:0] e_a, e_b;

  always #5 pclk = ~pclk;

  ipc_mailbox_fifo dut (
    .pclk(pclk), .preset(preset),
    .a_psel(a_psel), .a_penable(a_penable), .a_pwrite(a_pwrite), .a_paddr(a_paddr),
    .a_pwdata(a_pwdata), .a_prdata(a_prdata), .a_pready(a_pready), .a_pslverr(a_pslverr),
    .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite), .b_paddr(b_paddr),
    .b_pwdata(b_pwdata), .b_prdata(b_prdata), .b_pready(b_pready), .b_pslverr(b_pslverr),
    .a_msg_irq(a_msg_irq), .b_msg_irq(b_msg_irq)
  );

  // One APB transfer on port p; returns at the negedge right after the access edge.
  task automatic apb(input int p, input logic w, input logic [5:0] addr, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    @(negedge pclk);
    if (p == 0) begin
      a_psel = 1'b1; a_penable = 1'b0; a_pwrite = w; a_paddr = {26'd0, addr}; a_pwdata = wd;
      exp_q_a.push_back({ee, er});
    end else begin
      b_psel = 1'b1; b_penable = 1'b0; b_pwrite = w; b_paddr = {26'd0, addr}; b_pwdata = wd;
      exp_q_b.push_back({ee, er});
    end
    @(negedge pclk);
    if (p == 0) a_penable = 1'b1; else b_penable = 1'b1;
    @(negedge pclk);
    if (p == 0) begin a_psel = 1'b0; a_penable = 1'b0; end
    else begin b_psel = 1'b0; b_penable = 1'b0; end
  endtask

  task automatic wr(input int p, input logic [5:0] addr, input logic [31:0] wd, input logic ee);
    apb(p, 1'b1, addr, wd, 32'd0, ee);
  endtask

  task automatic rd(input int p, input logic [5:0] addr, input logic [31:0] er, input logic ee);
    apb(p, 1'b0, addr, 32'd0, er, ee);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks every completed access against the head of that port's queue.
  always @(negedge pclk) begin
    #2;
    if (a_psel && a_penable) begin
      n_cmp++;
      if (exp_q_a.size() == 0) begin
        n_fail++;
        $display("FAIL apb_a: unexpected access addr=%h", a_paddr);
      end else begin
        e_a = exp_q_a.pop_front();
        if ({a_pslverr, a_prdata} !== e_a || a_pready !== 1'b1) begin
          n_fail++;
          $display("FAIL apb_a addr=%h: got err=%b data=%h ready=%b, expected err=%b data=%h ready=1",
                   a_paddr, a_pslverr, a_prdata, a_pready, e_a[32], e_a[31:0]);
        end
      end
    end
    if (b_psel && b_penable) begin
      n_cmp++;
      if (exp_q_b.size() == 0) begin
        n_fail++;
        $display("FAIL apb_b: unexpected access addr=%h", b_paddr);
      end else begin
        e_b = exp_q_b.pop_front();
        if ({b_pslverr, b_prdata} !== e_b || b_pready !== 1'b1) begin
          n_fail++;
          $display("FAIL apb_b addr=%h: got err=%b data=%h ready=%b, expected err=%b data=%h ready=1",
                   b_paddr, b_pslverr, b_prdata, b_pready, e_b[32], e_b[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1;
    a_psel = 0; a_penable = 0; a_pwrite = 0; a_paddr = '0; a_pwdata = '0;
    b_psel = 0; b_penable = 0; b_pwrite = 0; b_paddr = '0; b_pwdata = '0;
    repeat (3) @(negedge pclk);
    preset = 1'b0;

    // Reset state
    chk("rst_a_irq", 32'(a_msg_irq), 32'd0);
    chk("rst_b_irq", 32'(b_msg_irq), 32'd0);
    chk("idle_a_prdata", a_prdata, 32'd0);
    chk("idle_a_pslverr", 32'(a_pslverr), 32'd0);
    rd(0, STA, 32'h0000_0000, 0);
    rd(1, STA, 32'h0000_0000, 0);
    rd(0, CTL, 32'h0000_0101, 0);
    rd(1, CTL, 32'h0000_0101, 0);
    rd(0, HID, 32'd0, 0);
    rd(1, HID, 32'd1, 0);
    rd(0, TXD, 32'd0, 0);
    rd(0, CLR, 32'd0, 0);
    wr(0, RXD, 32'h55, 1);
    rd(0, 6'h20, 32'd0, 1);

    // Basic A->B transfer and IRQ at threshold 1
    chk("irq_b_before_push", 32'(b_msg_irq), 32'd0);
    wr(0, TXD, 32'h11, 0);
    chk("irq_b_after_first_push", 32'(b_msg_irq), 32'd1);
    wr(0, TXD, 32'h22, 0);
    wr(0, TXD, 32'h33, 0);
    rd(1, STA, 32'h0000_0301, 0);
    rd(0, STA, 32'h0003_0000, 0);
    rd(1, RXD, 32'h11, 0);
    rd(1, RXD, 32'h22, 0);
    chk("irq_b_one_left", 32'(b_msg_irq), 32'd1);
    rd(1, RXD, 32'h33, 0);
    chk("irq_b_after_last_pop", 32'(b_msg_irq), 32'd0);

    // Overflow and underflow, then clear
    for (int i = 1; i <= 4; i++) wr(0, TXD, 32'(i), 0);
    wr(0, TXD, 32'd5, 1);
    rd(0, STA, 32'h0004_0006, 0);
    rd(1, STA, 32'h0000_0401, 0);
    for (int i = 1; i <= 4; i++) rd(1, RXD, 32'(i), 0);
    rd(1, RXD, 32'd0, 1);
    rd(1, STA, 32'h0000_0008, 0);
    rd(0, STA, 32'h0000_0004, 0);
    wr(0, CLR, 32'h0C, 0);
    wr(1, CLR, 32'h0C, 0);
    rd(0, STA, 32'h0000_0000, 0);
    rd(1, STA, 32'h0000_0000, 0);

    // Simultaneous push/pop on a full and on an empty FIFO
    for (int i = 0; i < 4; i++) wr(0, TXD, 32'hA0 + 32'(i), 0);
    fork
      wr(0, TXD, 32'hA4, 1);
      rd(1, RXD, 32'hA0, 0);
    join
    rd(1, STA, 32'h0000_0301, 0);
    rd(0, STA, 32'h0003_0004, 0);
    rd(1, RXD, 32'hA1, 0);
    rd(1, RXD, 32'hA2, 0);
    rd(1, RXD, 32'hA3, 0);
    fork
      wr(0, TXD, 32'hB0, 0);
      rd(1, RXD, 32'd0, 1);
    join
    rd(1, STA, 32'h0000_0109, 0);
    rd(1, RXD, 32'hB0, 0);
    wr(0, CLR, 32'h0C, 0);
    wr(1, CLR, 32'h0C, 0);

    // Threshold 3, flush, reset with words queued
    wr(1, CTL, 32'h0000_0301, 0);
    rd(1, CTL, 32'h0000_0301, 0);
    wr(0, TXD, 32'hC1, 0);
    chk("thr3_irq_after_1", 32'(b_msg_irq), 32'd0);
    wr(0, TXD, 32'hC2, 0);
    chk("thr3_irq_after_2", 32'(b_msg_irq), 32'd0);
    wr(0, TXD, 32'hC3, 0);
    chk("thr3_irq_after_3", 32'(b_msg_irq), 32'd1);
    wr(1, CLR, 32'h200, 0);
    chk("flush_irq_b", 32'(b_msg_irq), 32'd0);
    rd(1, STA, 32'h0000_0000, 0);
    rd(0, STA, 32'h0000_0000, 0);
    wr(0, TXD, 32'hD1, 0);
    wr(0, TXD, 32'hD2, 0);
    wr(1, TXD, 32'hE1, 0);
    chk("pre_reset_irq_a", 32'(a_msg_irq), 32'd1);
    rd(1, STA, 32'h0001_0201, 0);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    chk("post_reset_irq_a", 32'(a_msg_irq), 32'd0);
    chk("post_reset_irq_b", 32'(b_msg_irq), 32'd0);
    rd(0, STA, 32'h0000_0000, 0);
    rd(1, STA, 32'h0000_0000, 0);
    rd(1, CTL, 32'h0000_0101, 0);
    rd(0, RXD, 32'd0, 1);

`ifdef IPC_MBOX_DOORBELL_EN
    wr(0, DBL, 32'h05, 0);
    chk("db_irq_b_set", 32'(b_msg_irq), 32'd1);
    chk("db_irq_a_quiet", 32'(a_msg_irq), 32'd0);
    rd(1, DBL, 32'h05, 0);
    rd(0, DBL, 32'h00, 0);
    wr(1, DBC, 32'h05, 0);
    chk("db_irq_b_clear", 32'(b_msg_irq), 32'd0);
    rd(1, DBL, 32'h00, 0);
`else
    wr(0, DBL, 32'h05, 1);
    rd(1, DBL, 32'd0, 1);
    wr(1, DBC, 32'h05, 1);
    chk("no_db_irq_b", 32'(b_msg_irq), 32'd0);
`endif

    @(negedge pclk);
    #3;
    chk("queue_a_drained", 32'(exp_q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(exp_q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
